// File: rtl/mem_pkg.sv
// =============================================================================
// mem_pkg : shared constants for the data memory responder path
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

package mem_pkg;

  localparam int WORD_W = 32;

  // RW encoding shared with memory_control
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef logic [WORD_W-1:0] word_t;

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// =============================================================================
// mem_array : single-port DEPTH x 32 RAM, synchronous write and registered read
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  word_t                wdata,
  output word_t                rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  word_t mem [DEPTH];
  word_t rdata_q;
  word_t rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register holds its value until the next read strobe
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_memory_responder.sv
// =============================================================================
// data_memory_responder : zero-filled word RAM with wait states and ready pulse
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

module data_memory_responder
  import mem_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_req,
  input  logic              RW,
  input  logic [WORD_W-1:0] address_in,
  input  logic [WORD_W-1:0] RAM_in,
  output logic [WORD_W-1:0] RAM_out,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              addr_err
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  logic [1:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 rw_q, rw_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 err_q, err_d;
  word_t                data_q, data_d;

  logic                 ram_we;
  logic                 ram_re;
  logic [ADDR_BITS-1:0] ram_addr;
  word_t                ram_wdata;
  word_t                ram_rdata;
  logic                 req_err;

  assign req_err = (address_in >> ADDR_BITS) != '0;

  // The RAM read is issued on the edge entering RESP so RAM_out is valid with mem_ready
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    err_d     = err_q;
    data_d    = data_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = data_q;
    case (state_q)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_addr  = ptr_q;
        ram_wdata = '0;
        ptr_d     = ptr_q + ADDR_BITS'(1);
        if (ptr_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (mem_req) begin
          rw_d   = RW;
          addr_d = address_in[ADDR_BITS-1:0];
          err_d  = req_err;
          data_d = RAM_in;
          if (WAIT_STATES == 0) begin
            state_d  = ST_RESP;
            ram_addr = address_in[ADDR_BITS-1:0];
            ram_re   = (RW == RW_READ);
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
          ram_re  = (rw_q == RW_READ);
        end
      end
      ST_RESP: begin
        ram_we  = (rw_q == RW_WRITE) && !err_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      cnt_q   <= '0;
      rw_q    <= RW_READ;
      addr_q  <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_mem_array (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we && reset_n),
    .re      (ram_re && reset_n),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  assign RAM_out   = ram_rdata;
  assign mem_ready = (state_q == ST_RESP);
  assign addr_err  = (state_q == ST_RESP) && err_q;
  assign mem_busy  = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_data_memory_responder.sv
// =============================================================================
// tb_data_memory_responder : randomized bench with a behavioural memory model
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req  [2];
  logic        rw   [2];
  logic [31:0] ain  [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic        rdy  [2];
  logic        busy [2];
  logic        aerr [2];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: one word array per instance plus the last value read out
  logic [31:0] mm      [2][256];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  // Instance 0 uses one wait state, instance 1 none
  data_memory_responder #(.ADDR_BITS(8), .WAIT_STATES(1)) dut_ws1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_req    (req[0]),
    .RW         (rw[0]),
    .address_in (ain[0]),
    .RAM_in     (din[0]),
    .RAM_out    (dout[0]),
    .mem_ready  (rdy[0]),
    .mem_busy   (busy[0]),
    .addr_err   (aerr[0])
  );

  data_memory_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) dut_ws0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_req    (req[1]),
    .RW         (rw[1]),
    .address_in (ain[1]),
    .RAM_in     (din[1]),
    .RAM_out    (dout[1]),
    .mem_ready  (rdy[1]),
    .mem_busy   (busy[1]),
    .addr_err   (aerr[1])
  );

  function automatic int ws_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic string pfx(input int i);
    return (i == 0) ? "ws1" : "ws0";
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 256; a++) mm[i][a] = 32'h0;
      last_rd[i] = 32'h0;
    end
  endtask

  task automatic do_reset(input int cycles);
    int n;
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) req[i] = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        chk({pfx(i), "_rst_rdy"},  32'(rdy[i]),  32'h0);
        chk({pfx(i), "_rst_err"},  32'(aerr[i]), 32'h0);
        chk({pfx(i), "_rst_busy"}, 32'(busy[i]), 32'h1);
        chk({pfx(i), "_rst_out"},  dout[i],      32'h0);
      end
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy[0] !== 1'b0 && n < 1000);
    chk("init_len", 32'(n), 32'd256);
    chk("init_busy_ws0", 32'(busy[1]), 32'h0);
  endtask

  // One request spanning its full service period; with jitter the strobe stays
  // high and the inputs are scrambled after acceptance, which must be ignored.
  task automatic run_txn(input int i, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input bit jitter);
    int          p;
    logic        err;
    logic [7:0]  lo;
    logic [31:0] exp_out;
    p   = ws_of(i) + 2;
    lo  = a[7:0];
    err = (a[31:8] != 24'h0);
    exp_out = (r == 1'b1) ? mm[i][lo] : last_rd[i];
    for (int j = 0; j < p; j++) begin
      @(negedge clk);
      if (j == 0) begin
        req[i] = 1'b1; rw[i] = r; ain[i] = a; din[i] = d;
      end else if (jitter) begin
        req[i] = 1'b1; rw[i] = 1'($urandom); ain[i] = $urandom; din[i] = $urandom;
      end else begin
        req[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      chk({pfx(i), "_rdy"},  32'(rdy[i]),  32'(j == ws_of(i)));
      chk({pfx(i), "_busy"}, 32'(busy[i]), 32'(j != p - 1));
      if (j == ws_of(i)) begin
        chk({pfx(i), "_err"},  32'(aerr[i]), 32'(err));
        chk({pfx(i), "_data"}, dout[i],      exp_out);
      end else begin
        chk({pfx(i), "_err_idle"}, 32'(aerr[i]), 32'h0);
      end
    end
    if (r == 1'b1) last_rd[i] = exp_out;
    else if (!err) mm[i][lo] = d;
  endtask

  task automatic quiet(input int i);
    @(negedge clk);
    req[i] = 1'b0;
  endtask

  task automatic random_txns(input int i, input int count);
    logic [31:0] a;
    for (int k = 0; k < count; k++) begin
      a = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) a = a | (32'($urandom_range(1, 255)) << 8);
      run_txn(i, 1'($urandom), a, $urandom, 1'($urandom));
    end
    quiet(i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; rw[i] = 1'b1; ain[i] = '0; din[i] = '0;
    end
    model_reset();

    do_reset(2);
    run_txn(0, 1'b1, 32'h05, 32'h0, 1'b0);

    // Round trip, then out-of-range write must not disturb the aliased word
    run_txn(0, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0);
    run_txn(0, 1'b1, 32'h10,  32'h0,        1'b0);
    run_txn(0, 1'b0, 32'h110, 32'h12345678, 1'b0);
    run_txn(0, 1'b1, 32'h10,  32'h0,        1'b0);
    run_txn(0, 1'b1, 32'h110, 32'h0,        1'b0);

    for (int k = 0; k < 8; k++) run_txn(0, 1'b0, 32'(16 + k), $urandom, 1'b1);
    for (int k = 0; k < 12; k++) run_txn(0, 1'b1, 32'($urandom_range(16, 23)), 32'h0, 1'b1);
    quiet(0);

    random_txns(0, 40);

    run_txn(1, 1'b1, 32'h05, 32'h0, 1'b0);
    run_txn(1, 1'b0, 32'h01, 32'hC0DE0001, 1'b1);
    run_txn(1, 1'b0, 32'h02, 32'hC0DE0002, 1'b1);
    quiet(1);
    run_txn(1, 1'b1, 32'h01, 32'h0, 1'b0);
    run_txn(1, 1'b1, 32'h02, 32'h0, 1'b0);
    random_txns(1, 40);

    // Abort a write while it sits in its wait state
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'b0; ain[0] = 32'h20; din[0] = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy[0]), 32'h1);
    chk("abort_rdy",  32'(rdy[0]),  32'h0);
    do_reset(2);
    run_txn(0, 1'b1, 32'h20, 32'h0, 1'b0);
    run_txn(1, 1'b1, 32'h01, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
